// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - PRBS-7/PRBS-13 receive-side bit-error checker
//
// Self-synchronises a local LFSR to the received serial stream, declares lock
// after LOCK_THRESH consecutive matching predictions, then counts compared
// bits and mismatches. Loses lock when LOSS_THRESH errors land in one
// WINDOW-bit observation window.
//
// Ports:
//   clock, reset   single clock, synchronous active-high reset
//   control        pattern select: 0 = PRBS-7, 1 = PRBS-13
//   rx_valid       qualifies rx_bit; nothing advances while low
//   rx_bit         received serial bit
//   clear_cnt      synchronous clear of bit/error and window counters
//   locked         high while in LOCKED
//   state          0 = SEED, 1 = VERIFY, 2 = LOCKED
//   bit_count      bits compared while LOCKED (saturating)
//   err_count      mismatches counted while LOCKED (saturating)
//   first_err_idx  bit_count value at the first counted error
//                  (only with PRBS_CHECKER_FIRST_ERR_EN)
//   first_err_vld  first_err_idx is valid
//                  (only with PRBS_CHECKER_FIRST_ERR_EN)
module prbs_checker #(
   parameter int CNT_W       = 32,
   parameter int ERR_W       = 32,
   parameter int LOCK_THRESH = 16,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             control,
   input  logic             rx_valid,
   input  logic             rx_bit,
   input  logic             clear_cnt,
   output logic             locked,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] bit_count,
   output logic [ERR_W-1:0] err_count
`ifdef PRBS_CHECKER_FIRST_ERR_EN
   ,
   output logic [CNT_W-1:0] first_err_idx,
   output logic             first_err_vld
`endif
);

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
   localparam int WIN_W   = $clog2(WINDOW + 1);
   localparam int LERR_W  = $clog2(LOSS_THRESH + 1);

   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_THRESH - 1);
   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
   localparam logic [LERR_W-1:0]  LOSS_LAST  = LERR_W'(LOSS_THRESH - 1);

   state_t             cur_st, nxt_st;
   logic               ctrl_q;
   logic [12:0]        s_q, s_d;
   logic [3:0]         seed_q, seed_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [WIN_W-1:0]   wb_q, wb_d;
   logic [LERR_W-1:0]  we_q, we_d;
   logic [CNT_W-1:0]   bc_q, bc_d;
   logic [ERR_W-1:0]   ec_q, ec_d;
`ifdef PRBS_CHECKER_FIRST_ERR_EN
   logic [CNT_W-1:0]   fe_idx_q, fe_idx_d;
   logic               fe_vld_q, fe_vld_d;
`endif

   logic               pred;
   logic               mismatch;
   logic [3:0]         seed_last;

   // Prediction always uses the registered mode so a mid-stream change of
   // control cannot mix the two polynomials within one cycle.
   assign pred      = ctrl_q ? (s_q[12] ^ s_q[11] ^ s_q[1] ^ s_q[0])
                             : (s_q[6] ^ s_q[5]);
   assign mismatch  = rx_bit ^ pred;
   assign seed_last = ctrl_q ? 4'd12 : 4'd6;

   always_comb begin
      nxt_st  = cur_st;
      s_d     = s_q;
      seed_d  = seed_q;
      match_d = match_q;
      wb_d    = wb_q;
      we_d    = we_q;
      bc_d    = bc_q;
      ec_d    = ec_q;
`ifdef PRBS_CHECKER_FIRST_ERR_EN
      fe_idx_d = fe_idx_q;
      fe_vld_d = fe_vld_q;
`endif
      if (rx_valid) begin
         case (cur_st)
            SEED: begin
               s_d = {s_q[11:0], rx_bit};
               if (seed_q == seed_last) begin
                  nxt_st  = VERIFY;
                  seed_d  = 4'd0;
                  match_d = '0;
               end else begin
                  seed_d = seed_q + 4'd1;
               end
            end
            VERIFY: begin
               s_d = {s_q[11:0], pred};
               if (mismatch) begin
                  nxt_st = SEED;
                  seed_d = 4'd0;
               end else if (match_q == MATCH_LAST) begin
                  nxt_st  = LOCKED;
                  match_d = '0;
                  wb_d    = '0;
                  we_d    = '0;
               end else begin
                  match_d = match_q + MATCH_W'(1);
               end
            end
            LOCKED: begin
               // Reference free-runs so received errors never corrupt it.
               s_d  = {s_q[11:0], pred};
               bc_d = (&bc_q) ? bc_q : bc_q + CNT_W'(1);
               if (mismatch) begin
                  ec_d = (&ec_q) ? ec_q : ec_q + ERR_W'(1);
`ifdef PRBS_CHECKER_FIRST_ERR_EN
                  if (!fe_vld_q) begin
                     fe_idx_d = bc_q;
                     fe_vld_d = 1'b1;
                  end
`endif
               end
               if (mismatch && (we_q == LOSS_LAST)) begin
                  nxt_st = SEED;
                  seed_d = 4'd0;
                  wb_d   = '0;
                  we_d   = '0;
               end else if (wb_q == WIN_LAST) begin
                  wb_d = '0;
                  we_d = '0;
               end else begin
                  wb_d = wb_q + WIN_W'(1);
                  we_d = we_q + LERR_W'(mismatch);
               end
            end
            default: nxt_st = SEED;
         endcase
      end

      // A pattern change discards whatever this cycle's bit would have done.
      if (ctrl_q != control) begin
         nxt_st  = SEED;
         s_d     = s_q;
         seed_d  = 4'd0;
         match_d = '0;
         wb_d    = '0;
         we_d    = '0;
         bc_d    = bc_q;
         ec_d    = ec_q;
`ifdef PRBS_CHECKER_FIRST_ERR_EN
         fe_idx_d = fe_idx_q;
         fe_vld_d = fe_vld_q;
`endif
      end

      // Statistics clear beats a coincident bit; the FSM is left alone.
      if (clear_cnt) begin
         bc_d = '0;
         ec_d = '0;
         wb_d = '0;
         we_d = '0;
`ifdef PRBS_CHECKER_FIRST_ERR_EN
         fe_idx_d = '0;
         fe_vld_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cur_st  <= SEED;
         locked  <= 1'b0;
         ctrl_q  <= control;
         s_q     <= '0;
         seed_q  <= '0;
         match_q <= '0;
         wb_q    <= '0;
         we_q    <= '0;
         bc_q    <= '0;
         ec_q    <= '0;
`ifdef PRBS_CHECKER_FIRST_ERR_EN
         fe_idx_q <= '0;
         fe_vld_q <= 1'b0;
`endif
      end else begin
         cur_st  <= nxt_st;
         locked  <= (nxt_st == LOCKED);
         ctrl_q  <= control;
         s_q     <= s_d;
         seed_q  <= seed_d;
         match_q <= match_d;
         wb_q    <= wb_d;
         we_q    <= we_d;
         bc_q    <= bc_d;
         ec_q    <= ec_d;
`ifdef PRBS_CHECKER_FIRST_ERR_EN
         fe_idx_q <= fe_idx_d;
         fe_vld_q <= fe_vld_d;
`endif
      end
   end

   assign state     = cur_st;
   assign bit_count = bc_q;
   assign err_count = ec_q;
`ifdef PRBS_CHECKER_FIRST_ERR_EN
   assign first_err_idx = fe_idx_q;
   assign first_err_vld = fe_vld_q;
`endif

endmodule
